screen_writer: RTL

Write-side engine for the Hack 512x256 screen RAM (8192 x 16-bit words), the counterpart of the VGA frame-buffer reader. Accepts word-write, pixel-set, pixel-clear and full-screen fill commands over a valid/ready handshake. Pixel commands are turned into a read-modify-write of the containing word, using the same x/y-to-word mapping the display side reads with. Sits between the CPU/debug command source and the write port of the screen RAM.

---
 rtl/hack_screen_pkg.sv | 35 +++
 rtl/screen_writer_if.sv | 22 ++
 rtl/screen_pixel_map.sv | 18 +
 rtl/screen_writer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/hack_screen_pkg.sv
// Shared constants, state encoding and pixel helper for the Hack screen
// writer and frame-buffer reader.
package hack_screen_pkg;

    localparam logic [1:0] OP_WORD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_FILL = 2'b11;

    localparam int SCREEN_WORDS  = 8192;
    localparam int WORDS_PER_ROW = 32;
    localparam int SCREEN_W      = 512;
    localparam int SCREEN_H      = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_FILL  = 2'b11
    } state_e;

    // Set or clear a single pixel bit inside a screen word, other bits kept.
    function automatic logic [15:0] pixel_rmw(input logic [15:0] word,
                                              input logic [3:0]  bit_idx,
                                              input logic        set_px);
        logic [15:0] mask;
        mask = 16'h0001 << bit_idx;
        if (set_px) begin
            pixel_rmw = word | mask;
        end else begin
            pixel_rmw = word & ~mask;
        end
    endfunction

endpackage

// File: rtl/screen_writer_if.sv
// Command channel of the screen writer: valid/ready handshake plus status.
interface screen_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [12:0] cmd_addr;
    logic [15:0] cmd_data;
    logic        done;
    logic        busy;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_addr, cmd_data,
        input  cmd_ready, done, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_addr, cmd_data,
        output cmd_ready, done, busy
    );
endinterface

// File: rtl/screen_pixel_map.sv
// Pixel coordinate to screen-word mapping, shared with the display reader.
// Word = y*32 + x/16, bit = x%16 (bit 0 is the leftmost pixel of the word).
module screen_pixel_map
    import hack_screen_pkg::*;
(
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    output logic [12:0] word_addr,
    output logic [3:0]  bit_idx
);

    // Concatenation is y*32 + x[8:4]; always fits in 13 bits.
    always_comb begin
        word_addr = {y, x[8:4]};
        bit_idx   = x[3:0];
    end

endmodule

// File: rtl/screen_writer.sv
// Write-side engine for the Hack screen RAM: word writes, pixel set/clear
// via read-modify-write, and full-screen fill. All outputs are flops.
module screen_writer
    import hack_screen_pkg::*;
#(
    parameter int RAM_LATENCY = 1,
    parameter int FILL_WORDS  = 8192
) (
    input  logic                 clk,
    input  logic                 rst_n,
    screen_writer_if.slave       cmd,
    output logic [12:0]          ram_address,
    input  logic [15:0]          ram_read_value,
    output logic [15:0]          ram_write_data,
    output logic                 ram_we
);

    // Read data is sampled on the RAM_LATENCY-th edge after the address launch.
    localparam logic [1:0]  LAT_LAST  = 2'(RAM_LATENCY - 1);
    localparam logic [12:0] FILL_LAST = 13'(FILL_WORDS - 1);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  bit_q, bit_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic [12:0] fill_cnt_q, fill_cnt_d;
    logic [12:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;

    logic [12:0] pix_addr_s;
    logic [3:0]  pix_bit_s;

    screen_pixel_map u_map (
        .x         (cmd.cmd_x),
        .y         (cmd.cmd_y),
        .word_addr (pix_addr_s),
        .bit_idx   (pix_bit_s)
    );

    // Next-state and next-output decode for the command FSM.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        bit_d      = bit_q;
        lat_cnt_d  = lat_cnt_q;
        fill_cnt_d = fill_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;
        ready_d    = ready_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid && ready_q) begin
                    op_d       = cmd.cmd_op;
                    bit_d      = pix_bit_s;
                    lat_cnt_d  = 2'd0;
                    fill_cnt_d = 13'd0;
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
                    case (cmd.cmd_op)
                        OP_WORD: begin
                            state_d = ST_WRITE;
                            addr_d  = cmd.cmd_addr;
                            wdata_d = cmd.cmd_data;
                            we_d    = 1'b1;
                            done_d  = 1'b1;
                        end
                        OP_SET, OP_CLR: begin
                            state_d = ST_READ;
                            addr_d  = pix_addr_s;
                            wdata_d = 16'h0000;
                        end
                        OP_FILL: begin
                            state_d = ST_FILL;
                            addr_d  = 13'd0;
                            wdata_d = cmd.cmd_data;
                            we_d    = 1'b1;
                            done_d  = (FILL_LAST == 13'd0);
                        end
                        default: begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            ready_d = 1'b1;
                        end
                    endcase
                end else begin
                    addr_d  = 13'd0;
                    wdata_d = 16'h0000;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            ST_READ: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = ST_WRITE;
                    wdata_d = pixel_rmw(ram_read_value, bit_q, (op_q == OP_SET));
                    we_d    = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                addr_d  = 13'd0;
                wdata_d = 16'h0000;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            ST_FILL: begin
                // Terminal test on the configured last address, not on wrap.
                if (fill_cnt_q == FILL_LAST) begin
                    state_d = ST_IDLE;
                    addr_d  = 13'd0;
                    wdata_d = 16'h0000;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    fill_cnt_d = fill_cnt_q + 13'd1;
                    addr_d     = fill_cnt_q + 13'd1;
                    we_d       = 1'b1;
                    done_d     = ((fill_cnt_q + 13'd1) == FILL_LAST);
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = 13'd0;
                wdata_d = 16'h0000;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= 2'b00;
            bit_q      <= 4'd0;
            lat_cnt_q  <= 2'd0;
            fill_cnt_q <= 13'd0;
            addr_q     <= 13'd0;
            wdata_q    <= 16'h0000;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            bit_q      <= bit_d;
            lat_cnt_q  <= lat_cnt_d;
            fill_cnt_q <= fill_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign cmd.cmd_ready  = ready_q;
    assign cmd.done       = done_q;
    assign cmd.busy       = busy_q;
    assign ram_address    = addr_q;
    assign ram_write_data = wdata_q;
    assign ram_we         = we_q;

endmodule
